// File: rtl/hazard_scoreboard_pkg.sv
// Shared settings for the hazard scoreboard: register-file sizing and
// result-latency classes of the execution units.
package hazard_scoreboard_pkg;

    localparam int REG_FILE_DEPTH = 5;

    localparam int LAT_ALU  = 0;
    localparam int LAT_MUL  = 1;
    localparam int LAT_LOAD = 2;

    typedef struct packed {
        logic src2;
        logic src1;
    } hazard_src_t;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard slot: pending-write flag plus cycles until the result
// becomes forwardable.
module scoreboard_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] lat,
    input  logic             clear,
    output logic             pend,
    output logic [LAT_W-1:0] cnt
);

    // A new writer beats a same-cycle retirement of the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            pend <= 1'b1;
            cnt  <= lat;
        end else if (clear) begin
            pend <= 1'b0;
            cnt  <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order issue scoreboard: blocks the ID instruction on RAW/WAW hazards
// against outstanding register writes and counts stall cycles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_FILE_DEPTH,
    parameter int LAT_W      = 3,
    parameter int FWD_EN     = 1,
    parameter int PERF_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  has_src1,
    input  logic                  has_src2,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic                  wb_en,
    input  logic [LAT_W-1:0]      id_lat,
    output logic                  id_ready,
    output logic                  hazard_detected,
    output logic [1:0]            hazard_src,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  flush,
    output logic [PERF_W-1:0]     stall_cycles
);

    localparam int NREG = 2**REG_ADDR_W;

    logic [NREG-1:0]  pend;
    logic [NREG-1:0]  load;
    logic [NREG-1:0]  clear;
    logic [LAT_W-1:0] cnt [NREG];
    hazard_src_t      blk;
    logic             waw;
    logic             issue;

    // Without forwarding a source stays blocked until writeback retires it.
    always_comb begin
        blk.src1 = has_src1 && pend[src1] && ((FWD_EN == 0) || (cnt[src1] != '0));
        blk.src2 = has_src2 && pend[src2] && ((FWD_EN == 0) || (cnt[src2] != '0));
        waw      = wb_en && pend[dest];
        hazard_detected = id_valid && !flush && (blk.src1 || blk.src2 || waw);
    end

    assign id_ready   = !hazard_detected;
    assign hazard_src = blk;
    assign issue      = id_valid && id_ready && !flush;

    for (genvar i = 0; i < NREG; i++) begin : g_entry
        assign load[i]  = issue && wb_en && (dest == REG_ADDR_W'(i));
        assign clear[i] = wb_valid && (wb_dest == REG_ADDR_W'(i));

        scoreboard_entry #(
            .LAT_W (LAT_W)
        ) u_entry (
            .clk   (clk),
            .rst   (rst),
            .load  (load[i]),
            .lat   (id_lat),
            .clear (clear[i]),
            .pend  (pend[i]),
            .cnt   (cnt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (hazard_detected && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one forwarding instance with default
// settings and one non-forwarding instance with a 3-bit stall counter.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, has_src1, has_src2, wb_en, wb_valid, flush;
    logic [4:0] src1, src2, dest, wb_dest;
    logic [2:0] id_lat;

    logic        rdy0, haz0, rdy1, haz1;
    logic [1:0]  hsrc0, hsrc1;
    logic [15:0] stall0;
    logic [2:0]  stall1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .has_src1(has_src1), .has_src2(has_src2), .dest(dest), .wb_en(wb_en),
        .id_lat(id_lat), .id_ready(rdy0), .hazard_detected(haz0),
        .hazard_src(hsrc0), .wb_valid(wb_valid), .wb_dest(wb_dest),
        .flush(flush), .stall_cycles(stall0)
    );

    hazard_scoreboard #(
        .FWD_EN (0),
        .PERF_W (3)
    ) u_nofwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .has_src1(has_src1), .has_src2(has_src2), .dest(dest), .wb_en(wb_en),
        .id_lat(id_lat), .id_ready(rdy1), .hazard_detected(haz1),
        .hazard_src(hsrc1), .wb_valid(wb_valid), .wb_dest(wb_dest),
        .flush(flush), .stall_cycles(stall1)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        id_valid = 0; has_src1 = 0; has_src2 = 0; wb_en = 0; wb_valid = 0;
        flush = 0; src1 = '0; src2 = '0; dest = '0; wb_dest = '0; id_lat = '0;
    endtask

    task automatic drive(input logic v, input int s1, input logic h1, input int s2,
                         input logic h2, input int d, input logic we, input int lat);
        id_valid = v;
        src1 = 5'(s1); has_src1 = h1;
        src2 = 5'(s2); has_src2 = h2;
        dest = 5'(d);  wb_en = we;
        id_lat = 3'(lat);
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        clr_in();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #2;
        check("rst rdy0", rdy0, 1);
        check("rst haz0", haz0, 0);
        check("rst hsrc0", hsrc0, 0);
        check("rst stall0", stall0, 0);
        check("rst rdy1", rdy1, 1);
        check("rst stall1", stall1, 0);

        // ALU result, immediate consumer: forwarding vs. no forwarding
        drive(1, 0, 0, 0, 0, 3, 1, LAT_ALU); #2;
        check("A issue rdy0", rdy0, 1);
        check("A issue rdy1", rdy1, 1);
        tick();
        drive(1, 3, 1, 0, 0, 0, 0, 0); #2;
        check("A fwd haz0", haz0, 0);
        check("A nofwd haz1", haz1, 1);
        check("A nofwd hsrc1", hsrc1, 1);
        tick();
        wb_valid = 1; wb_dest = 5'd3; #2;
        check("A wb same cycle haz1", haz1, 1);
        tick();
        wb_valid = 0; #2;
        check("A after wb rdy1", rdy1, 1);
        check("A stall1", stall1, 2);
        check("A stall0", stall0, 0);
        tick();
        do_reset();

        // LOAD with latency 2, consumer on src2
        drive(1, 0, 0, 0, 0, 5, 1, LAT_LOAD); #2;
        check("B issue rdy0", rdy0, 1);
        tick();
        drive(1, 0, 0, 5, 1, 0, 0, 0); #2;
        check("B c1 hsrc0", hsrc0, 2);
        tick(); #2;
        check("B c2 hsrc0", hsrc0, 2);
        check("B c2 haz0", haz0, 1);
        tick(); #2;
        check("B c3 rdy0", rdy0, 1);
        check("B stall0", stall0, 2);
        tick();
        repeat (5) tick();
        #2;
        check("B sat stall1", stall1, 7);
        has_src2 = 0; #2;
        check("B unused src2 haz1", haz1, 0);
        has_src2 = 1; flush = 1; #2;
        check("B flush haz1", haz1, 0);
        check("B flush rdy1", rdy1, 1);
        tick();
        flush = 0; wb_valid = 1; wb_dest = 5'd9; #2;
        check("B post flush haz1", haz1, 1);
        tick();
        wb_valid = 0; #2;
        check("B idle wb haz1", haz1, 1);
        do_reset();

        // WAW on r4
        drive(1, 0, 0, 0, 0, 4, 1, LAT_MUL); tick();
        drive(1, 0, 0, 0, 0, 4, 1, LAT_ALU); #2;
        check("C waw haz0", haz0, 1);
        check("C waw hsrc0", hsrc0, 0);
        tick();
        tick();
        wb_valid = 1; wb_dest = 5'd4; #2;
        check("C wb same cycle haz0", haz0, 1);
        tick();
        wb_valid = 0; #2;
        check("C after wb rdy0", rdy0, 1);
        tick(); #2;
        check("C re-pend haz0", haz0, 1);
        do_reset();

        // register 0 is an ordinary register
        drive(1, 0, 0, 0, 0, 0, 1, LAT_MUL); tick();
        drive(1, 0, 1, 0, 0, 0, 0, 0); #2;
        check("C r0 haz0", haz0, 1);
        check("C r0 hsrc0", hsrc0, 1);
        tick(); #2;
        check("C r0 fwd rdy0", rdy0, 1);
        do_reset();

        // issue and writeback to r6 in the same cycle, then stall count and mid-stall reset
        drive(1, 0, 0, 0, 0, 6, 1, LAT_MUL);
        wb_valid = 1; wb_dest = 5'd6;
        tick();
        wb_valid = 0;
        drive(1, 0, 0, 0, 0, 6, 1, LAT_ALU); #2;
        check("D issue wins haz0", haz0, 1);
        repeat (5) tick();
        #2;
        check("D stall0", stall0, 5);
        rst = 1;
        tick();
        rst = 0; #2;
        check("D rst rdy0", rdy0, 1);
        check("D rst haz0", haz0, 0);
        check("D rst hsrc0", hsrc0, 0);
        check("D rst stall0", stall0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
